// File: rtl/bit_serial_add_ctrl.sv
// bit_serial_add_ctrl
//   Sequenced bit-serial add/subtract engine. An operand pair is accepted
//   over a valid/ready handshake and loaded into shift registers. One
//   full-adder bit is then resolved per clock, LSB first, for WIDTH clocks.
//   The result is presented over a second valid/ready handshake. This block
//   owns load/shift control, carry storage and cycle counting.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = reset asserted)
//   in_valid   operand pair a/b/sub is valid
//   in_ready   block can accept an operand pair (IDLE)
//   a, b       operands, WIDTH bits
//   sub        0 = a+b, 1 = a-b
//   out_valid  sum/cout/ovf are valid (DONE)
//   out_ready  consumer accepts the result
//   sum        result, modulo 2^WIDTH
//   cout       unsigned carry out (subtract: 1 = no borrow)
//   ovf        signed two's-complement overflow
//   busy       high while bits are being processed (RUN)

module bit_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_bit;
  logic             last_bit;

  // Full adder on the current LSBs and the stored carry.
  always_comb begin
    s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    c_bit    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Datapath. Subtract is a + ~b + 1: b is inverted at load and the
  // carry flop is seeded with 1. The result register shifts in place,
  // so sum only holds the final value once DONE is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          sum   <= {s_bit, sum[WIDTH-1:1]};
          carry <= c_bit;
          if (last_bit) begin
            cnt  <= '0;
            cout <= c_bit;
            // carry flop here is the carry into the MSB
            ovf  <= carry ^ c_bit;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
module tb_bit_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        iv8, ir8, sb8, ov8, or8, co8, of8, bz8;
  logic [7:0]  a8, b8, s8;
  logic        iv16, ir16, sb16, ov16, or16, co16, of16, bz16;
  logic [15:0] a16, b16, s16;

  bit_serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .sub(sb8), .out_valid(ov8), .out_ready(or8),
    .sum(s8), .cout(co8), .ovf(of8), .busy(bz8)
  );

  bit_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .sub(sb16), .out_valid(ov16), .out_ready(or16),
    .sum(s16), .cout(co16), .ovf(of16), .busy(bz16)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t q8[$];
  res_t q16[$];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer add of a and (b or its two's complement).
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic s);
    res_t        r;
    logic [31:0] mask;
    logic [31:0] bb;
    logic [32:0] full;
    int          m;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    bb     = s ? (~b & mask) : (b & mask);
    full   = {1'b0, a & mask} + {1'b0, bb} + {32'd0, s};
    r.sum  = full[31:0] & mask;
    r.cout = full[w];
    m      = w - 1;
    if (s) r.ovf = (a[m] != b[m]) && (r.sum[m] != a[m]);
    else   r.ovf = (a[m] == b[m]) && (r.sum[m] != a[m]);
    return r;
  endfunction

  function automatic logic g_ov(input int w);  return (w == 8) ? ov8 : ov16; endfunction
  function automatic logic g_ir(input int w);  return (w == 8) ? ir8 : ir16; endfunction
  function automatic logic g_bz(input int w);  return (w == 8) ? bz8 : bz16; endfunction
  function automatic logic g_co(input int w);  return (w == 8) ? co8 : co16; endfunction
  function automatic logic g_of(input int w);  return (w == 8) ? of8 : of16; endfunction
  function automatic logic [31:0] g_sum(input int w);
    return (w == 8) ? {24'd0, s8} : {16'd0, s16};
  endfunction

  task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic v);
    if (w == 8) begin a8 = a[7:0];   b8 = b[7:0];   sb8 = s;  iv8 = v;  end
    else        begin a16 = a[15:0]; b16 = b[15:0]; sb16 = s; iv16 = v; end
  endtask

  task automatic set_valid(input int w, input logic v);
    if (w == 8) iv8 = v; else iv16 = v;
  endtask

  task automatic set_ready(input int w, input logic r);
    if (w == 8) or8 = r; else or16 = r;
  endtask

  task automatic push(input int w, input res_t r);
    if (w == 8) q8.push_back(r); else q16.push_back(r);
  endtask

  task automatic pop(input int w, input string tag, output res_t r);
    int n;
    n = (w == 8) ? q8.size() : q16.size();
    check({tag, " scoreboard_nonempty"}, 32'(n > 0), 32'd1);
    if (n > 0) r = (w == 8) ? q8.pop_front() : q16.pop_front();
    else       r = '0;
  endtask

  task automatic cmp_result(input int w, input string tag, input res_t e);
    check({tag, " sum"},  g_sum(w), e.sum);
    check({tag, " cout"}, 32'(g_co(w)), 32'(e.cout));
    check({tag, " ovf"},  32'(g_of(w)), 32'(e.ovf));
  endtask

  // Full transaction: accept, measure latency, compare, optional
  // backpressure for 'hold' cycles, then release and check return to IDLE.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int hold, input string tag);
    int   lat;
    res_t e;
    @(negedge clk);
    check({tag, " in_ready_idle"}, 32'(g_ir(w)), 32'd1);
    drive(w, a, b, s, 1'b1);
    push(w, model(w, a, b, s));
    @(posedge clk); #1;
    set_valid(w, 1'b0);
    check({tag, " in_ready_drop"}, 32'(g_ir(w)), 32'd0);
    check({tag, " busy"}, 32'(g_bz(w)), 32'd1);
    lat = 0;
    while (!g_ov(w) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(w));
    pop(w, tag, e);
    cmp_result(w, tag, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      cmp_result(w, {tag, " hold"}, e);
      check({tag, " hold_in_ready"}, 32'(g_ir(w)), 32'd0);
      check({tag, " hold_out_valid"}, 32'(g_ov(w)), 32'd1);
    end
    @(negedge clk);
    set_ready(w, 1'b1);
    @(posedge clk); #1;
    check({tag, " out_valid_drop"}, 32'(g_ov(w)), 32'd0);
    check({tag, " in_ready_back"}, 32'(g_ir(w)), 32'd1);
    @(negedge clk);
    set_ready(w, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    res_t e;
    int   t, t1, t2, got, cyc;

    reset = 1'b0;
    drive(8, 0, 0, 1'b0, 1'b0);  or8 = 1'b0;
    drive(16, 0, 0, 1'b0, 1'b0); or16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",  32'(ir8), 32'd1);
    check("reset out_valid", 32'(ov8), 32'd0);
    check("reset busy",      32'(bz8), 32'd0);
    check("reset sum",       32'(s8),  32'd0);
    check("reset cout",      32'(co8), 32'd0);
    check("reset ovf",       32'(of8), 32'd0);
    check("reset16 in_ready", 32'(ir16), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Basic adds
    run_op(8, 100, 55, 1'b0, 0, "add_100_55");
    run_op(8, 255, 1, 1'b0, 0, "add_255_1");
    run_op(8, 128, 128, 1'b0, 0, "add_128_128");

    // Subtracts
    run_op(8, 5, 3, 1'b1, 0, "sub_5_3");
    run_op(8, 3, 5, 1'b1, 0, "sub_3_5");
    run_op(8, 128, 1, 1'b1, 0, "sub_128_1");

    // Backpressure
    run_op(8, 200, 100, 1'b0, 5, "backpressure");

    // Abort mid-RUN with an asynchronous reset
    @(negedge clk);
    drive(8, 77, 99, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_valid(8, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("abort pre busy", 32'(bz8), 32'd1);
    reset = 1'b0;
    #1;
    check("abort in_ready",  32'(ir8), 32'd1);
    check("abort out_valid", 32'(ov8), 32'd0);
    check("abort busy",      32'(bz8), 32'd0);
    check("abort sum",       32'(s8),  32'd0);
    check("abort cout",      32'(co8), 32'd0);
    check("abort ovf",       32'(of8), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(8, 10, 20, 1'b0, 0, "after_abort");

    // in_valid held high through RUN with a/b/sub changing
    @(negedge clk);
    drive(8, 8'h40, 8'h41, 1'b0, 1'b1);
    push(8, model(8, 32'h40, 32'h41, 1'b0));
    or8 = 1'b1;  // early out_ready must have no effect
    @(posedge clk); #1;
    cyc = 0;
    while (!ov8 && cyc < 50) begin
      check("held in_ready", 32'(ir8), 32'd0);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      sb8 = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    check("held latency", 32'(cyc), 32'd8);
    pop(8, "held", e);
    cmp_result(8, "held", e);
    @(negedge clk);
    iv8 = 1'b0;
    @(posedge clk); #1;
    check("held out_valid_drop", 32'(ov8), 32'd0);
    check("held in_ready_back", 32'(ir8), 32'd1);
    @(negedge clk);
    or8 = 1'b0;

    // WIDTH=16 single op
    run_op(16, 32'hFFFF, 32'h0001, 1'b0, 0, "w16_ffff_1");

    // WIDTH=16 back-to-back with out_ready held high
    @(negedge clk);
    drive(16, 32'h1234, 32'h4321, 1'b1, 1'b1);
    or16 = 1'b1;
    push(16, model(16, 32'h1234, 32'h4321, 1'b1));
    push(16, model(16, 32'h1234, 32'h4321, 1'b1));
    t = 0; t1 = -1; t2 = -1; got = 0;
    while (got < 2 && t < 200) begin
      @(posedge clk); #1;
      t++;
      if (ov16) begin
        pop(16, "b2b", e);
        cmp_result(16, "b2b", e);
        if (got == 0) t1 = t; else t2 = t;
        got++;
      end
    end
    @(negedge clk);
    iv16 = 1'b0;
    check("b2b first_latency", 32'(t1), 32'd17);
    check("b2b period", 32'(t2 - t1), 32'd18);
    repeat (3) @(posedge clk);
    #1;
    check("b2b idle in_ready", 32'(ir16), 32'd1);
    check("b2b idle out_valid", 32'(ov16), 32'd0);
    check("b2b scoreboard_empty", 32'(q16.size() + q8.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bit_serial_add_ctrl.md
Name: bit_serial_add_ctrl

Overview:
Sequenced bit-serial add/subtract engine. It accepts an operand pair over a valid/ready handshake and captures it into internal shift registers. It then runs one full-adder bit per clock, LSB first, for WIDTH cycles and presents the result over a second valid/ready handshake. It is the scheduling wrapper that owns load/shift control, carry storage and cycle counting for the serial adder datapath, so that upstream logic never drives mode or counts cycles itself.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  operand pair a/b/sub is valid
in_ready  output  1  block can accept an operand pair
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result fields are valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  result
cout  output  1  final carry out (for subtract: 1 = no borrow)
ovf  output  1  signed two's-complement overflow
busy  output  1  high in RUN state

Behaviour:
- States: IDLE, RUN, DONE; 2-bit state register.
- Reset (reset=0, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - sum=0, cout=0, ovf=0; bit counter=0; carry flop=0.
  - Operand shift registers cleared.
  - Reset asserted mid-RUN or in DONE aborts the operation with no output.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load A_sh<=a; B_sh<=(sub ? ~b : b); carry<=sub; counter<=0; state<=RUN.
  - in_ready drops in the cycle after acceptance.
- RUN:
  - in_ready=0, busy=1; in_valid is ignored.
  - Each edge: s = A_sh[0]^B_sh[0]^carry; c = majority(A_sh[0],B_sh[0],carry).
  - A_sh and B_sh shift right with zero fill.
  - Result register shifts right with s entering at MSB; carry<=c; counter++.
  - On the edge where counter==WIDTH-1 (the WIDTH-th bit):
    - cout<=c.
    - ovf<=(carry into MSB) xor c, where carry into MSB is the carry flop value at that edge.
    - state<=DONE.
- DONE:
  - out_valid=1; sum/cout/ovf are held stable while out_ready=0.
  - On an edge with out_ready=1: state<=IDLE and out_valid drops the next cycle.
  - There is no same-cycle re-accept: in_ready=0 in DONE.
- Latency: out_valid rises exactly WIDTH clocks after the in_valid/in_ready acceptance edge.
- Throughput: one operation per WIDTH+2 cycles when out_ready is held high.
- sum is visible only when out_valid=1; its value in other states is don't-care to the consumer. The implementation shifts in place.
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - cout is the unsigned carry (for subtract: 1 when a>=b unsigned).
  - ovf is the signed overflow for the selected operation.
- Boundary conditions:
  - in_valid held high through RUN/DONE: no second capture occurs until IDLE is re-entered.
  - a/b changing during RUN: no effect.
  - out_ready high before DONE: no effect.
  - Counter never exceeds WIDTH-1.
  - Illegal state encoding: return to IDLE.

Test Plan:
1. Reset release, then a=100, b=55, sub=0, in_valid for one cycle -> out_valid exactly 8 cycles after acceptance; sum=155, cout=0, ovf=1.
2. a=255, b=1, sub=0 -> sum=0, cout=1, ovf=0. Then a=128, b=128 -> sum=0, cout=1, ovf=1.
3. Subtract: a=5, b=3, sub=1 -> sum=2, cout=1, ovf=0. Then a=3, b=5, sub=1 -> sum=254, cout=0, ovf=0. Then a=128, b=1, sub=1 -> sum=127, ovf=1.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/cout/ovf stable and in_ready=0 throughout. out_ready=1 -> IDLE next cycle, in_ready=1.
5. Abort and ignore:
   - Pull reset low on RUN cycle 4 -> all outputs at reset values immediately (asynchronous).
   - After release, the new op a=10, b=20 yields 30 with no residue from the aborted op.
   - in_valid held high during RUN with changing a/b -> exactly one capture per op.
6. WIDTH=16 instance: a=0xFFFF, b=0x0001 -> out_valid after 16 cycles; sum=0, cout=1. Back-to-back ops with out_ready=1 -> 18-cycle period.
